// File: rtl/defast_ctrl_pipe.sv
// Stage-4 de-FAST control decode: resolves MC/MT fields across lanes and beats through a
// copy dictionary, then decodes them into message-mux and N-type controls over a 2-stage stream.
module defast_ctrl_pipe #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned MSG_W  = 328,
  parameter int unsigned MC_POS = 0,
  parameter int unsigned MT_POS = 2,
  parameter int unsigned CTL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dict_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH-1:0]       in_ch_en,
  input  logic [NUM_CH*MSG_W-1:0] in_msg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH-1:0]       out_ch_en,
  output logic [NUM_CH*CTL_W-1:0] out_mux_ctl,
  output logic [NUM_CH*CTL_W-1:0] out_ntype,
  output logic [NUM_CH-1:0]       out_copy_err,
  output logic [7:0]              dict_mc,
  output logic [7:0]              dict_mt
);

  function automatic logic [CTL_W-1:0] dec_mc(input logic [7:0] b);
    case (b)
      8'h61:   return CTL_W'(1);
      8'h64:   return CTL_W'(2);
      8'h6B:   return CTL_W'(3);
      8'h71:   return CTL_W'(4);
      8'h4E:   return CTL_W'(5);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CTL_W-1:0] dec_mt(input logic [7:0] b);
    case (b)
      8'h4C:   return CTL_W'(1);
      8'h4D:   return CTL_W'(2);
      8'h4E:   return CTL_W'(3);
      8'h52:   return CTL_W'(4);
      8'h53:   return CTL_W'(5);
      default: return '0;
    endcase
  endfunction

  logic [7:0] dict_mc_q, dict_mt_q, dict_mc_d, dict_mt_d;
  logic       dict_mc_vld_q, dict_mt_vld_q, dict_mc_vld_d, dict_mt_vld_d;

  logic                    s1_valid_q;
  logic [NUM_CH*8-1:0]     s1_mc_q, s1_mt_q;
  logic [NUM_CH-1:0]       s1_en_q, s1_err_q;
  logic                    out_valid_q;
  logic [NUM_CH-1:0]       out_en_q, out_err_q;
  logic [NUM_CH*CTL_W-1:0] out_mux_q, out_ntype_q, mux_d, ntype_d;

  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  // Copy resolution: a carry (value, valid) seeded from the dictionary walks up the lanes.
  logic [MSG_W-1:0]    lane_msg;
  logic                p, c, t;
  logic [7:0]          mc_raw, mt_raw, mc_val, mt_val, mc_carry, mt_carry;
  logic                mc_cvld, mt_cvld;
  logic [NUM_CH*8-1:0] res_mc, res_mt;
  logic [NUM_CH-1:0]   res_err;

  always_comb begin
    lane_msg = '0;
    p        = 1'b0;
    c        = 1'b0;
    t        = 1'b0;
    mc_raw   = '0;
    mt_raw   = '0;
    mc_val   = '0;
    mt_val   = '0;
    mc_carry = dict_clr ? 8'h00 : dict_mc_q;
    mt_carry = dict_clr ? 8'h00 : dict_mt_q;
    mc_cvld  = !dict_clr && dict_mc_vld_q;
    mt_cvld  = !dict_clr && dict_mt_vld_q;
    res_mc   = '0;
    res_mt   = '0;
    res_err  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_msg = in_msg[i*MSG_W +: MSG_W];
      p        = lane_msg[MC_POS+1];
      c        = lane_msg[MC_POS];
      t        = lane_msg[MT_POS];
      mc_raw   = p ? lane_msg[MSG_W-1 -: 8] : lane_msg[MSG_W-9 -: 8];
      if ({p, c} == 2'b00)      mt_raw = lane_msg[MSG_W-17 -: 8];
      else if ({p, c} == 2'b11) mt_raw = lane_msg[MSG_W-1 -: 8];
      else                      mt_raw = lane_msg[MSG_W-9 -: 8];
      if (in_ch_en[i]) begin
        if (c) begin
          mc_val     = mc_cvld ? mc_carry : 8'h00;
          res_err[i] = res_err[i] | !mc_cvld;
        end else begin
          mc_val  = mc_raw;
          mc_cvld = 1'b1;
        end
        if (t) begin
          mt_val     = mt_cvld ? mt_carry : 8'h00;
          res_err[i] = res_err[i] | !mt_cvld;
        end else begin
          mt_val  = mt_raw;
          mt_cvld = 1'b1;
        end
        mc_carry         = mc_val;
        mt_carry         = mt_val;
        res_mc[i*8 +: 8] = mc_val;
        res_mt[i*8 +: 8] = mt_val;
      end
    end
  end

  always_comb begin
    dict_mc_d     = dict_mc_q;
    dict_mt_d     = dict_mt_q;
    dict_mc_vld_d = dict_mc_vld_q;
    dict_mt_vld_d = dict_mt_vld_q;
    if (dict_clr) begin
      dict_mc_d     = '0;
      dict_mt_d     = '0;
      dict_mc_vld_d = 1'b0;
      dict_mt_vld_d = 1'b0;
    end
    if (accept && |in_ch_en) begin
      dict_mc_d     = mc_carry;
      dict_mt_d     = mt_carry;
      dict_mc_vld_d = mc_cvld;
      dict_mt_vld_d = mt_cvld;
    end
  end

  always_comb begin
    mux_d   = '0;
    ntype_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mux_d[i*CTL_W +: CTL_W]   = dec_mc(s1_mc_q[i*8 +: 8]);
      ntype_d[i*CTL_W +: CTL_W] = dec_mt(s1_mt_q[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dict_mc_q     <= '0;
      dict_mt_q     <= '0;
      dict_mc_vld_q <= 1'b0;
      dict_mt_vld_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_mc_q       <= '0;
      s1_mt_q       <= '0;
      s1_en_q       <= '0;
      s1_err_q      <= '0;
      out_valid_q   <= 1'b0;
      out_en_q      <= '0;
      out_err_q     <= '0;
      out_mux_q     <= '0;
      out_ntype_q   <= '0;
    end else begin
      dict_mc_q     <= dict_mc_d;
      dict_mt_q     <= dict_mt_d;
      dict_mc_vld_q <= dict_mc_vld_d;
      dict_mt_vld_q <= dict_mt_vld_d;
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mc_q  <= res_mc;
          s1_mt_q  <= res_mt;
          s1_en_q  <= in_ch_en;
          s1_err_q <= res_err;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_en_q    <= s1_en_q;
          out_err_q   <= s1_err_q;
          out_mux_q   <= mux_d;
          out_ntype_q <= ntype_d;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_ch_en    = out_en_q;
  assign out_copy_err = out_err_q;
  assign out_mux_ctl  = out_mux_q;
  assign out_ntype    = out_ntype_q;
  assign dict_mc      = dict_mc_q;
  assign dict_mt      = dict_mt_q;

endmodule

// File: tb/tb_defast_ctrl_pipe.sv
// Directed bench for defast_ctrl_pipe with hand-computed expectations.
module tb_defast_ctrl_pipe;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned MSG_W  = 328;
  localparam int unsigned CTL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    dict_clr = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_CH-1:0]       in_ch_en = '0;
  logic [NUM_CH*MSG_W-1:0] in_msg = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [NUM_CH-1:0]       out_ch_en;
  logic [NUM_CH*CTL_W-1:0] out_mux_ctl;
  logic [NUM_CH*CTL_W-1:0] out_ntype;
  logic [NUM_CH-1:0]       out_copy_err;
  logic [7:0]              dict_mc;
  logic [7:0]              dict_mt;

  int checks = 0;
  int failures = 0;

  defast_ctrl_pipe #(
    .NUM_CH(NUM_CH), .MSG_W(MSG_W), .MC_POS(0), .MT_POS(2), .CTL_W(CTL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dict_clr(dict_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch_en(in_ch_en), .in_msg(in_msg), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch_en(out_ch_en), .out_mux_ctl(out_mux_ctl), .out_ntype(out_ntype),
    .out_copy_err(out_copy_err), .dict_mc(dict_mc), .dict_mt(dict_mt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic p, input logic c, input logic t,
                                          input logic [7:0] f0, input logic [7:0] f1,
                                          input logic [7:0] f2);
    logic [MSG_W-1:0] m;
    m = '0;
    m[MSG_W-1 -: 8]  = f0;
    m[MSG_W-9 -: 8]  = f1;
    m[MSG_W-17 -: 8] = f2;
    m[1] = p;
    m[0] = c;
    m[2] = t;
    return m;
  endfunction

  task automatic set_lane(input int i, input logic [MSG_W-1:0] m);
    in_msg[i*MSG_W +: MSG_W] = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat presented for a single edge; pipeline is expected to be ready.
  task automatic beat(input logic [NUM_CH-1:0] en, input logic clr);
    in_ch_en = en;
    dict_clr = clr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dict_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [7:0] mcv [4];
  logic [7:0] mtv [4];
  logic [2:0] got [$];
  int         idx_in;
  logic       acc, xfer;
  logic [2:0] mux_snap;

  initial begin
    mcv[0] = 8'h61; mcv[1] = 8'h64; mcv[2] = 8'h6B; mcv[3] = 8'h71;
    mtv[0] = 8'h4C; mtv[1] = 8'h4D; mtv[2] = 8'h4E; mtv[3] = 8'h52;

    // Reset state
    #1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mux", 64'(out_mux_ctl), 64'd0);
    chk("rst_ntype", 64'(out_ntype), 64'd0);
    chk("rst_err", 64'(out_copy_err), 64'd0);
    chk("rst_dict_mc", 64'(dict_mc), 64'd0);
    chk("rst_dict_mt", 64'(dict_mt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: explicit MC 'a' at F1, MT 'L' at F2
    in_msg = '0;
    set_lane(0, mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h61, 8'h4C));
    beat(3'b001, 1'b0);
    chk("t1_dict_mc", 64'(dict_mc), 64'h61);
    chk("t1_dict_mt", 64'(dict_mt), 64'h4C);
    chk("t1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_mux", 64'(out_mux_ctl), 64'h001);
    chk("t1_ntype", 64'(out_ntype), 64'h001);
    chk("t1_en", 64'(out_ch_en), 64'h1);
    chk("t1_err", 64'(out_copy_err), 64'h0);

    // 2: lane0 'q' explicit, lanes 1 and 2 copy both fields in-beat
    in_msg = '0;
    set_lane(0, mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h71, 8'h4D));
    set_lane(1, mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00));
    set_lane(2, mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00));
    beat(3'b111, 1'b0);
    chk("t2_dict_mc", 64'(dict_mc), 64'h71);
    chk("t2_dict_mt", 64'(dict_mt), 64'h4D);
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_mux", 64'(out_mux_ctl), 64'h124);
    chk("t2_ntype", 64'(out_ntype), 64'h092);
    chk("t2_err", 64'(out_copy_err), 64'h0);
    tick();

    // 3: copy from empty dictionary after reset, then explicit 'd'
    do_reset();
    chk("t3_rst_valid", 64'(out_valid), 64'd0);
    chk("t3_rst_dict", 64'(dict_mc), 64'd0);
    in_msg = '0;
    set_lane(0, mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h52, 8'h00));
    beat(3'b001, 1'b0);
    chk("t3a_dict_mc", 64'(dict_mc), 64'h00);
    chk("t3a_dict_mt", 64'(dict_mt), 64'h52);
    tick();
    chk("t3a_err", 64'(out_copy_err), 64'h1);
    chk("t3a_mux", 64'(out_mux_ctl), 64'h000);
    chk("t3a_ntype", 64'(out_ntype), 64'h004);
    in_msg = '0;
    set_lane(0, mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h64, 8'h00));
    beat(3'b001, 1'b0);
    chk("t3b_dict_mc", 64'(dict_mc), 64'h64);
    tick();
    chk("t3b_err", 64'(out_copy_err), 64'h0);
    chk("t3b_mux", 64'(out_mux_ctl), 64'h002);
    chk("t3b_ntype", 64'(out_ntype), 64'h004);
    tick();

    // 4: backpressure for 5 edges while offering 4 beats
    idx_in = 0;
    in_ch_en = 3'b001;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (idx_in < 4);
      in_msg = '0;
      if (idx_in < 4) set_lane(0, mk(1'b0, 1'b0, 1'b0, 8'h00, mcv[idx_in], mtv[idx_in]));
      #1;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      mux_snap = out_mux_ctl[2:0];
      tick();
      if (acc) idx_in++;
      if (xfer) got.push_back(mux_snap);
      if (cyc == 1) chk("t4_first_out", 64'(out_mux_ctl), 64'h001);
      if (cyc == 4) begin
        chk("t4_in_flight", 64'(idx_in), 64'd2);
        chk("t4_in_ready_low", 64'(in_ready), 64'd0);
        chk("t4_held_valid", 64'(out_valid), 64'd1);
        chk("t4_held_mux", 64'(out_mux_ctl), 64'h001);
        chk("t4_held_ntype", 64'(out_ntype), 64'h001);
        chk("t4_no_xfer", 64'(got.size()), 64'd0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t4_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < got.size(); k++) chk("t4_order", 64'(got[k]), 64'(k + 1));
    tick();
    tick();
    chk("t4_drained", 64'(out_valid), 64'd0);

    // 5: dict_clr together with an accepted beat
    in_msg = '0;
    set_lane(0, mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h61, 8'h00));
    set_lane(1, mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h6B, 8'h53));
    beat(3'b011, 1'b1);
    chk("t5_dict_mt", 64'(dict_mt), 64'h53);
    chk("t5_dict_mc", 64'(dict_mc), 64'h6B);
    tick();
    chk("t5_err", 64'(out_copy_err), 64'h1);
    chk("t5_mux", 64'(out_mux_ctl), 64'h019);
    chk("t5_ntype", 64'(out_ntype), 64'h028);
    dict_clr = 1'b1;
    tick();
    dict_clr = 1'b0;
    chk("t5_clr_mc", 64'(dict_mc), 64'h00);
    chk("t5_clr_mt", 64'(dict_mt), 64'h00);

    // 6: only lane1 enabled, MC 'N' from F0 (P=1), MT from F1
    in_msg = '0;
    set_lane(0, mk(1'b1, 1'b1, 1'b1, 8'h61, 8'h64, 8'h4C));
    set_lane(1, mk(1'b1, 1'b0, 1'b0, 8'h4E, 8'h4E, 8'h00));
    set_lane(2, mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h61, 8'h4C));
    beat(3'b010, 1'b0);
    chk("t6_dict_mc", 64'(dict_mc), 64'h4E);
    chk("t6_dict_mt", 64'(dict_mt), 64'h4E);
    tick();
    chk("t6_en", 64'(out_ch_en), 64'h2);
    chk("t6_mux", 64'(out_mux_ctl), 64'h028);
    chk("t6_ntype", 64'(out_ntype), 64'h018);
    chk("t6_err", 64'(out_copy_err), 64'h0);

    // Beat with no enabled lanes leaves the dictionary alone
    beat(3'b000, 1'b0);
    chk("t7_dict_mc", 64'(dict_mc), 64'h4E);
    tick();
    chk("t7_valid", 64'(out_valid), 64'd1);
    chk("t7_mux", 64'(out_mux_ctl), 64'h000);
    chk("t7_en", 64'(out_ch_en), 64'h0);

    // Reset with a beat in flight drops it and empties the dictionary
    beat(3'b010, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("t8_dropped", 64'(out_valid), 64'd0);
    chk("t8_dict", 64'(dict_mc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
